// File: rtl/random_timer_pkg.sv
// Shared types and helpers for the randomized enemy-fire timer.
// Holds the timer state encoding and the delay clamp.
package random_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    COUNT,
    FIRE
  } timer_state_t;

  function automatic int unsigned clamp_delay(
    input int unsigned v,
    input int unsigned lo,
    input int unsigned hi
  );
    if (v < lo)
      return lo;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

endpackage

// File: rtl/random_event_timer.sv
// Requests a random value, clamps it into a tick window, counts
// frame ticks down and holds a fire request until acknowledged.
module random_event_timer
  import random_timer_pkg::*;
#(
  parameter int unsigned SIZE_BITS    = 11,
  parameter int unsigned CNT_BITS     = 11,
  parameter int unsigned MIN_DELAY    = 30,
  parameter int unsigned MAX_DELAY    = 255,
  parameter int unsigned LATCH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 enable,
  input  logic                 tick,
  input  logic [SIZE_BITS-1:0] rand_val,
  input  logic                 fire_ack,
  output logic                 rand_req,
  output logic                 fire,
  output logic                 busy,
  output logic [CNT_BITS-1:0]  ticks_left
);

  localparam int unsigned WAIT_W = (LATCH_CYCLES > 1) ?
    $clog2(LATCH_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

  timer_state_t      state;
  logic [WAIT_W-1:0] wait_cnt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      rand_req   <= 1'b0;
      fire       <= 1'b0;
      ticks_left <= '0;
      wait_cnt   <= '0;
    end else begin
      rand_req <= 1'b0;
      // Dropping enable abandons everything, even a same-cycle tick/ack.
      if (!enable) begin
        state      <= IDLE;
        fire       <= 1'b0;
        ticks_left <= '0;
        wait_cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state    <= REQ;
            rand_req <= 1'b1;
          end
          REQ: begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
          WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
              ticks_left <= CNT_BITS'(clamp_delay(
                32'(rand_val), MIN_DELAY, MAX_DELAY));
              wait_cnt   <= '0;
              state      <= COUNT;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end
          COUNT: begin
            if (tick) begin
              ticks_left <= ticks_left - ONE;
              if (ticks_left == ONE) begin
                state <= FIRE;
                fire  <= 1'b1;
              end
            end
          end
          FIRE: begin
            if (fire_ack) begin
              fire     <= 1'b0;
              state    <= REQ;
              rand_req <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_random_event_timer.sv
// Scoreboard bench for random_event_timer: expected loads and
// fire tick counts are queued by the stimulus and popped by a monitor.
module tb_random_event_timer;

  localparam int SB = 11;
  localparam int CB = 11;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          enable = 1'b0;
  logic          tick = 1'b0;
  logic          fire_ack = 1'b0;
  logic [SB-1:0] rand_val = '0;
  logic          rand_req;
  logic          fire;
  logic          busy;
  logic [CB-1:0] ticks_left;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int tick_period = 2;
  int tick_seen = 0;
  int last_tick = 0;
  int req_cnt = 0;
  int exp_load[$];
  int exp_fire[$];

  logic          prev_req = 1'b0;
  logic          prev_fire = 1'b0;
  logic [CB-1:0] prev_tl = '0;

  always #5 clk = ~clk;

  random_event_timer dut (
    .clk       (clk),
    .resetN    (resetN),
    .enable    (enable),
    .tick      (tick),
    .rand_val  (rand_val),
    .fire_ack  (fire_ack),
    .rand_req  (rand_req),
    .fire      (fire),
    .busy      (busy),
    .ticks_left(ticks_left)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fire(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fire && n < budget);
    if (!fire) check("fire_timeout", 32'(fire), 1);
  endtask

  // Tick generator: one pulse every tick_period clocks.
  initial begin
    int c = 0;
    forever begin
      @(negedge clk);
      c++;
      tick = ((c % tick_period) == 0);
    end
  end

  // Monitor: sees outputs and the inputs about to be sampled.
  always begin
    @(negedge clk);
    #1;
    ncyc++;
    if (rand_req) begin
      req_cnt++;
      check("req_single", 32'(prev_req), 0);
    end
    if (prev_tl == '0 && ticks_left != '0) begin
      tick_seen = 0;
      if (exp_load.size() > 0)
        check("load", 32'(ticks_left), exp_load.pop_front());
      else
        check("load_unexpected", 32'(ticks_left), 0);
    end
    if (tick && ticks_left != '0) begin
      tick_seen++;
      last_tick = ncyc;
    end
    if (fire && !prev_fire) begin
      if (exp_fire.size() > 0)
        check("fire_ticks", tick_seen, exp_fire.pop_front());
      else
        check("fire_unexpected", 32'(fire), 0);
      check("fire_lat", ncyc - last_tick, 1);
      check("fire_tl", 32'(ticks_left), 0);
    end
    prev_req  = rand_req;
    prev_fire = fire;
    prev_tl   = ticks_left;
  end

  initial begin
    int vals[5]   = '{100, 5, 2000, 30, 255};
    int clamps[5] = '{100, 30, 255, 30, 255};
    int saved;
    int n;

    // Reset held with enable high and ticks toggling
    enable = 1'b1;
    resetN = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_req", 32'(rand_req), 0);
    check("rst_fire", 32'(fire), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tl", 32'(ticks_left), 0);

    rand_val = SB'(vals[0]);
    fire_ack = 1'b1;
    exp_load.push_back(clamps[0]);
    exp_fire.push_back(clamps[0]);
    resetN = 1'b1;
    @(negedge clk);
    check("req_first", 32'(rand_req), 1);
    @(negedge clk);
    check("req_falls", 32'(rand_req), 0);
    check("busy_run", 32'(busy), 1);
    tick_period = 4;

    // Nominal round then clamp rounds
    for (int i = 0; i < 5; i++) begin
      if (i == 4) fire_ack = 1'b0;
      wait_fire(3000);
      if (i < 4) begin
        rand_val = SB'(vals[i+1]);
        exp_load.push_back(clamps[i+1]);
        exp_fire.push_back(clamps[i+1]);
        @(negedge clk);
        check("fire_drop", 32'(fire), 0);
        check("req_after_fire", 32'(rand_req), 1);
        tick_period = 1;
      end
    end

    // Backpressure: fire held, ticks ignored, no new request
    tick_period = 10;
    repeat (50) begin
      @(negedge clk);
      check("bp_fire", 32'(fire), 1);
      check("bp_tl", 32'(ticks_left), 0);
      check("bp_req", 32'(rand_req), 0);
    end
    rand_val = SB'(50);
    exp_load.push_back(50);
    fire_ack = 1'b1;
    tick_period = 1;
    @(negedge clk);
    check("bp_release_fire", 32'(fire), 0);
    check("bp_release_req", 32'(rand_req), 1);
    fire_ack = 1'b0;

    // Abort in COUNT on the same clk as a tick
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ticks_left != CB'(7) && n < 200);
    check("abort_reach", 32'(ticks_left), 7);
    enable = 1'b0;
    saved = req_cnt;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_tl", 32'(ticks_left), 0);
    check("abort_fire", 32'(fire), 0);
    repeat (10) @(negedge clk);
    check("abort_noreq", req_cnt, saved);

    // Abort in FIRE with a same-clk acknowledge
    rand_val = SB'(40);
    exp_load.push_back(40);
    exp_fire.push_back(40);
    enable = 1'b1;
    wait_fire(500);
    enable = 1'b0;
    fire_ack = 1'b1;
    saved = req_cnt;
    @(negedge clk);
    check("fabort_fire", 32'(fire), 0);
    check("fabort_busy", 32'(busy), 0);
    check("fabort_req", 32'(rand_req), 0);
    repeat (5) @(negedge clk);
    check("fabort_noreq", req_cnt, saved);

    // Asynchronous reset in the middle of FIRE
    fire_ack = 1'b0;
    rand_val = SB'(35);
    exp_load.push_back(35);
    exp_fire.push_back(35);
    enable = 1'b1;
    wait_fire(500);
    #3;
    resetN = 1'b0;
    #1;
    check("arst_fire", 32'(fire), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_req", 32'(rand_req), 0);
    @(negedge clk);
    rand_val = SB'(60);
    exp_load.push_back(60);
    exp_fire.push_back(60);
    fire_ack = 1'b1;
    resetN = 1'b1;
    @(negedge clk);
    check("arst_restart_req", 32'(rand_req), 1);
    wait_fire(500);
    repeat (3) @(negedge clk);

    check("load_q_empty", exp_load.size(), 0);
    check("fire_q_empty", exp_fire.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
